// File: rtl/nanosoc_busmatrix_pkg.sv
// Shared AHB encodings and burst-length constants for the bus-matrix output stages.
// Also holds the burst-tracker debug view so checkers can bind to one type.
package nanosoc_busmatrix_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam int BEATS_4  = 4;
  localparam int BEATS_8  = 8;
  localparam int BEATS_16 = 16;

  typedef struct packed {
    logic [3:0] count;
    logic       hold;
    logic [3:0] et_cnt;
  } tracker_dbg_t;

  // Beats remaining after the NONSEQ beat of a fixed-length burst; 0 for open-ended bursts.
  function automatic logic [3:0] burst_start_count(input hburst_e burst);
    case (burst)
      HBURST_INCR16, HBURST_WRAP16: burst_start_count = 4'(BEATS_16 - 1);
      HBURST_INCR8,  HBURST_WRAP8:  burst_start_count = 4'(BEATS_8 - 1);
      HBURST_INCR4,  HBURST_WRAP4:  burst_start_count = 4'(BEATS_4 - 1);
      default:                      burst_start_count = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/nanosoc_arbiter_rr_sysio_if.sv
// Slave-port arbitration bundle between the input stages and the SYSIO output arbiter.
interface nanosoc_arbiter_rr_sysio_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
);
  import nanosoc_busmatrix_pkg::*;

  // HREADYM is the only qualifier: a beat (and every arbitration decision) is taken
  // on a rising clock edge where HREADYM=1; with HREADYM=0 nothing advances.
  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic                 no_port;
  tracker_dbg_t         dbg;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, grant_onehot, no_port, dbg
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, grant_onehot, no_port, dbg
  );
endinterface

// File: rtl/nanosoc_burst_tracker.sv
// Tracks the owned port's fixed-length burst: remaining beats, hold flag and a
// counter of back-to-back early-terminated bursts that eventually refuses hold.
module nanosoc_burst_tracker
  import nanosoc_busmatrix_pkg::*;
#(
  parameter int MAX_EARLY_TERM = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ready,
  input  logic         sel,
  input  logic [1:0]   trans,
  input  logic [2:0]   burst,
  output logic         next_hold,
  output tracker_dbg_t dbg
);

  localparam logic [3:0] ET_MAX = 4'(MAX_EARLY_TERM);

  logic [3:0] count_q, count_d;
  logic [3:0] et_q, et_d;
  logic       hold_q, hold_d;

  always_comb begin
    count_d = count_q;
    hold_d  = hold_q;
    if (!sel) begin
      count_d = 4'd0;
      hold_d  = 1'b0;
    end else begin
      case (htrans_e'(trans))
        HTRANS_NONSEQ: begin
          count_d = burst_start_count(hburst_e'(burst));
          hold_d  = (count_d != 4'd0);
          if (et_q == ET_MAX) begin
            count_d = 4'd0;
            hold_d  = 1'b0;
          end
        end
        HTRANS_SEQ: begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) hold_d = 1'b0;
        end
        HTRANS_BUSY: begin
          count_d = count_q;
          hold_d  = hold_q;
        end
        default: begin
          count_d = 4'd0;
          hold_d  = 1'b0;
        end
      endcase
    end

    // A NONSEQ arriving while still holding means the previous burst was cut short.
    et_d = et_q;
    if (!hold_d) begin
      et_d = 4'd0;
    end else if (hold_q && (trans == HTRANS_NONSEQ) && (et_q != ET_MAX)) begin
      et_d = et_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
      hold_q  <= 1'b0;
      et_q    <= 4'd0;
    end else if (ready) begin
      count_q <= count_d;
      hold_q  <= hold_d;
      et_q    <= et_d;
    end
  end

  assign next_hold  = hold_d;
  assign dbg.count  = count_q;
  assign dbg.hold   = hold_q;
  assign dbg.et_cnt = et_q;

endmodule

// File: rtl/nanosoc_arbiter_rr_sysio.sv
// Round-robin owner selection for a shared bus-matrix slave port, holding the
// owner across fixed-length bursts and locked sequences.
module nanosoc_arbiter_rr_sysio
  import nanosoc_busmatrix_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_W         = 2,
  parameter int MAX_EARLY_TERM = 2
) (
  input logic HCLK,
  input logic HRESET,
  nanosoc_arbiter_rr_sysio_if.slave bus
);

  logic                 next_hold;
  logic [PORT_W-1:0]    owner_q, owner_d, win, idx;
  logic                 np_q, np_d, found;
  logic [NUM_PORTS-1:0] grant_q, grant_d, owner_bit, cand;

  nanosoc_burst_tracker #(
    .MAX_EARLY_TERM(MAX_EARLY_TERM)
  ) u_tracker (
    .clk       (HCLK),
    .rst       (HRESET),
    .ready     (bus.HREADYM),
    .sel       (bus.HSELM),
    .trans     (bus.HTRANSM),
    .burst     (bus.HBURSTM),
    .next_hold (next_hold),
    .dbg       (bus.dbg)
  );

  always_comb begin
    owner_bit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      owner_bit[i] = (owner_q == PORT_W'(i));
    end
    // The owner keeps competing while it is still driving an active transfer.
    cand = bus.req_port;
    if (bus.HSELM && (bus.HTRANSM != HTRANS_IDLE)) cand = cand | owner_bit;

    // Search starts just after the owner and wraps, so the owner is considered last.
    found = 1'b0;
    win   = owner_q;
    idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PORT_W'((int'(owner_q) + i) % NUM_PORTS);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    owner_d = owner_q;
    np_d    = np_q;
    if (bus.HMASTLOCKM || next_hold) begin
      np_d = 1'b0;
    end else if (found) begin
      owner_d = win;
      np_d    = 1'b0;
    end else if (bus.HSELM) begin
      np_d = 1'b0;
    end else begin
      np_d = 1'b1;
    end

    grant_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_d[i] = !np_d && (owner_d == PORT_W'(i));
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      owner_q <= '0;
      np_q    <= 1'b1;
      grant_q <= '0;
    end else if (bus.HREADYM) begin
      owner_q <= owner_d;
      np_q    <= np_d;
      grant_q <= grant_d;
    end
  end

  assign bus.addr_in_port = owner_q;
  assign bus.no_port      = np_q;
  assign bus.grant_onehot = grant_q;

endmodule
